sphere_hit_scheduler: RTL and testbench
=======================================

Name: sphere_hit_scheduler

Overview:
Sequences one ray against a list of spheres in sphere memory. Issues one sphere per cycle to the pipelined sphere-hit datapath and tracks the closest hit. In any-hit mode (shadow rays) it stops issuing at the first hit. Sits between the ray dispatcher and the sphere-hit unit in the RayCore primitive stage; the ray payload is held stable upstream from accept until result handshake.

Parameters:
MAX_SPHERES, 16, capacity of sphere memory
IDX_W, $clog2(MAX_SPHERES), sphere index width
T_W, 32, fixed-point hit distance width (unsigned compare)
HIT_LAT, 4, fixed latency in cycles from hit_issue to hit_ret_valid (>=1)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ray_valid  in  1  new ray request
ray_ready  out  1  high only in IDLE
ray_any_hit  in  1  1 = any-hit mode; sampled on accept
num_spheres  in  IDX_W+1  spheres to test (0..MAX_SPHERES); sampled on accept
sph_rd_en  out  1  sphere memory read strobe
sph_rd_addr  out  IDX_W  sphere memory address
hit_issue  out  1  sphere data valid into hit unit (one cycle after sph_rd_en)
hit_issue_idx  out  IDX_W  index tag travelling with issued sphere
hit_ret_valid  in  1  hit unit result valid
hit_ret_hit  in  1  result is a hit
hit_ret_t  in  T_W  hit distance
hit_ret_idx  in  IDX_W  returned index tag
res_valid  out  1  final result valid
res_ready  in  1  downstream accepts result
res_hit  out  1  any sphere hit
res_t  out  T_W  closest (or first) hit distance; all-ones if no hit
res_idx  out  IDX_W  sphere index of res_t; 0 if no hit
err  out  1  sticky: unexpected hit_ret_valid (nothing outstanding)

Behaviour:
- Reset (async, any state): FSM=IDLE; all counters 0; ray_ready=1; sph_rd_en=hit_issue=res_valid=res_hit=err=0; res_t=all-ones; res_idx=0. Results arriving after reset with nothing outstanding are dropped and set err.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on ray_valid&ray_ready, latch mode and num_spheres. Clear best (best_hit=0, best_t=all-ones, best_idx=0), issue_ptr=0, outstanding=0. If num_spheres==0 go DONE, else ISSUE.
- ISSUE: each cycle sph_rd_en=1, sph_rd_addr=issue_ptr, issue_ptr++. hit_issue/hit_issue_idx is a 1-cycle delayed copy of sph_rd_en/addr. Last address (num_spheres-1) -> DRAIN. Back-to-back, no bubbles.
- outstanding: +1 per sph_rd_en, -1 per accepted hit_ret_valid; simultaneous inc/dec nets to 0. Width $clog2(HIT_LAT+3).
- Result merge (ISSUE or DRAIN, hit_ret_valid, outstanding>0): if hit_ret_hit and (best_hit==0 or hit_ret_t < best_t), update best. Tie on equal t keeps earlier (lower) index.
- Any-hit: first merged hit freezes best and ISSUE stops issuing immediately (no sph_rd_en that cycle), goes DRAIN. Later returns are counted but not merged.
- DRAIN: no issues. When outstanding reaches 0 (including same-cycle final return) -> DONE next cycle.
- DONE: res_valid=1, res_* = best registers, held stable until res_ready; then IDLE. res_ready ignored outside DONE.
- Latency for N spheres, closest mode, res_ready tied high: accept at cycle 0, res_valid at cycle N+HIT_LAT+2. num_spheres==0: res_valid at cycle 1.
- num_spheres>MAX_SPHERES: clamped to MAX_SPHERES.
- ray_valid in non-IDLE states is ignored (ray_ready=0).

Decomposition:
- Shared package: SchedState enum, T_FAR (all-ones T_W) constant, SphereIndex typedef sized by IDX_W.
- One natural sub-module: hit_best_tracker (compare/update best_t/best_idx/best_hit, any-hit freeze), reusable by a future triangle scheduler.
- Counter and FSM stay in top.

Test Plan:
- N=3, closest mode, HIT_LAT=4; returns t={0x500, 0x200, 0x300}, all hits -> res_hit=1, res_t=0x200, res_idx=1, res_valid at cycle 9.
- N=4, any-hit; sphere 1 hits t=0x800, sphere 3 hits t=0x100 -> res_idx=1, res_t=0x800; sph_rd_en never at addr 3 after freeze point; DONE only after outstanding=0.
- N=0 -> res_valid at cycle 1, res_hit=0, res_t=0xFFFFFFFF, res_idx=0; no sph_rd_en.
- N=2, equal t=0x400 for both -> res_idx=0; res_ready held low 5 cycles -> outputs stable, ray_ready=0 throughout.
- Reset asserted mid-ISSUE with 2 outstanding -> immediate IDLE, outputs at reset values; stray hit_ret_valid after release -> err=1, ignored.
- N=16 (MAX), no hits -> 16 consecutive sph_rd_en addresses 0..15, res_hit=0; then back-to-back second ray accepted the cycle after res handshake.

Source files
------------

// File: rtl/sphere_hit_scheduler_pkg.sv
// Shared types and default sizing for the sphere-hit scheduler and its best-hit tracker.
package sphere_hit_scheduler_pkg;

  localparam int DEF_MAX_SPHERES = 16;
  localparam int DEF_IDX_W       = $clog2(DEF_MAX_SPHERES);
  localparam int DEF_T_W         = 32;
  localparam int DEF_HIT_LAT     = 4;

  localparam logic [DEF_T_W-1:0] T_FAR = '1;

  typedef logic [DEF_IDX_W-1:0] SphereIndex;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } SchedState;

endpackage

// File: rtl/sphere_hit_scheduler_hit_best_tracker.sv
// Keeps the closest (or, in any-hit mode, the first) hit seen for the current ray.
module hit_best_tracker #(
  parameter int T_W   = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             any_hit_i,
  input  logic             merge_i,
  input  logic             hit_i,
  input  logic [T_W-1:0]   t_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             freeze_o,
  output logic             best_hit_o,
  output logic [T_W-1:0]   best_t_o,
  output logic [IDX_W-1:0] best_idx_o
);

  logic             best_hit_q, best_hit_d;
  logic [T_W-1:0]   best_t_q, best_t_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             frozen_q, frozen_d;
  logic             take;

  // Strict less-than: returns arrive in index order, so a tie keeps the lower index.
  always_comb begin
    take     = merge_i & hit_i & ~frozen_q & (~best_hit_q | (t_i < best_t_q));
    freeze_o = merge_i & hit_i & any_hit_i & ~frozen_q;
  end

  always_comb begin
    best_hit_d = best_hit_q;
    best_t_d   = best_t_q;
    best_idx_d = best_idx_q;
    frozen_d   = frozen_q | freeze_o;
    if (clear_i) begin
      best_hit_d = 1'b0;
      best_t_d   = '1;
      best_idx_d = '0;
      frozen_d   = 1'b0;
    end else if (take) begin
      best_hit_d = 1'b1;
      best_t_d   = t_i;
      best_idx_d = idx_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      best_hit_q <= 1'b0;
      best_t_q   <= '1;
      best_idx_q <= '0;
      frozen_q   <= 1'b0;
    end else begin
      best_hit_q <= best_hit_d;
      best_t_q   <= best_t_d;
      best_idx_q <= best_idx_d;
      frozen_q   <= frozen_d;
    end
  end

  assign best_hit_o = best_hit_q;
  assign best_t_o   = best_t_q;
  assign best_idx_o = best_idx_q;

endmodule

// File: rtl/sphere_hit_scheduler.sv
// Streams one ray's sphere list into the pipelined hit unit and reports the best hit.
module sphere_hit_scheduler
  import sphere_hit_scheduler_pkg::*;
#(
  parameter int MAX_SPHERES = DEF_MAX_SPHERES,
  parameter int IDX_W       = $clog2(MAX_SPHERES),
  parameter int T_W         = DEF_T_W,
  parameter int HIT_LAT     = DEF_HIT_LAT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic             ray_any_hit,
  input  logic [IDX_W:0]   num_spheres,
  output logic             sph_rd_en,
  output logic [IDX_W-1:0] sph_rd_addr,
  output logic             hit_issue,
  output logic [IDX_W-1:0] hit_issue_idx,
  input  logic             hit_ret_valid,
  input  logic             hit_ret_hit,
  input  logic [T_W-1:0]   hit_ret_t,
  input  logic [IDX_W-1:0] hit_ret_idx,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [T_W-1:0]   res_t,
  output logic [IDX_W-1:0] res_idx,
  output logic             err
);

  localparam int OUT_W = $clog2(HIT_LAT + 3);
  localparam logic [IDX_W:0] MAX_NUM = (IDX_W + 1)'(MAX_SPHERES);

  SchedState        state_q, state_d;
  logic             any_hit_q, any_hit_d;
  logic [IDX_W:0]   num_q, num_d;
  logic [IDX_W-1:0] issue_ptr_q, issue_ptr_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             hit_issue_q;
  logic [IDX_W-1:0] hit_issue_idx_q;
  logic             err_q, err_d;

  logic             accept;
  logic             ret_accept;
  logic             merge;
  logic             freeze;
  logic             last_issue;
  logic [IDX_W:0]   num_clamped;

  always_comb begin
    accept      = ray_valid & ray_ready;
    ret_accept  = hit_ret_valid & (outstanding_q != '0);
    merge       = ret_accept & ((state_q == S_ISSUE) | (state_q == S_DRAIN));
    last_issue  = ({1'b0, issue_ptr_q} == (num_q - 1'b1));
    num_clamped = (num_spheres > MAX_NUM) ? MAX_NUM : num_spheres;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (num_clamped == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (freeze || last_issue) state_d = S_DRAIN;
      S_DRAIN: if (outstanding_d == '0) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A freezing hit suppresses the read in the very cycle it returns.
  always_comb begin
    ray_ready = 1'b0;
    sph_rd_en = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      S_IDLE:  ray_ready = 1'b1;
      S_ISSUE: sph_rd_en = ~freeze;
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    any_hit_d     = any_hit_q;
    num_d         = num_q;
    issue_ptr_d   = issue_ptr_q;
    outstanding_d = outstanding_q;
    err_d         = err_q | (hit_ret_valid & (outstanding_q == '0));
    if (accept) begin
      any_hit_d     = ray_any_hit;
      num_d         = num_clamped;
      issue_ptr_d   = '0;
      outstanding_d = '0;
    end else begin
      if (sph_rd_en) issue_ptr_d = issue_ptr_q + 1'b1;
      case ({sph_rd_en, ret_accept})
        2'b10:   outstanding_d = outstanding_q + 1'b1;
        2'b01:   outstanding_d = outstanding_q - 1'b1;
        default: outstanding_d = outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      any_hit_q       <= 1'b0;
      num_q           <= '0;
      issue_ptr_q     <= '0;
      outstanding_q   <= '0;
      hit_issue_q     <= 1'b0;
      hit_issue_idx_q <= '0;
      err_q           <= 1'b0;
    end else begin
      any_hit_q       <= any_hit_d;
      num_q           <= num_d;
      issue_ptr_q     <= issue_ptr_d;
      outstanding_q   <= outstanding_d;
      hit_issue_q     <= sph_rd_en;
      hit_issue_idx_q <= issue_ptr_q;
      err_q           <= err_d;
    end
  end

  assign sph_rd_addr   = issue_ptr_q;
  assign hit_issue     = hit_issue_q;
  assign hit_issue_idx = hit_issue_idx_q;
  assign err           = err_q;

  hit_best_tracker #(
    .T_W  (T_W),
    .IDX_W(IDX_W)
  ) u_tracker (
    .clk       (clk),
    .resetn    (resetn),
    .clear_i   (accept),
    .any_hit_i (any_hit_q),
    .merge_i   (merge),
    .hit_i     (hit_ret_hit),
    .t_i       (hit_ret_t),
    .idx_i     (hit_ret_idx),
    .freeze_o  (freeze),
    .best_hit_o(res_hit),
    .best_t_o  (res_t),
    .best_idx_o(res_idx)
  );

endmodule

// File: tb/tb_sphere_hit_scheduler.sv
// Directed scoreboard bench: a behavioural hit unit answers issues after HIT_LAT cycles.
module tb_sphere_hit_scheduler;
  import sphere_hit_scheduler_pkg::*;

  localparam int HL = 4;

  logic        clk;
  logic        resetn;
  logic        ray_valid;
  logic        ray_ready;
  logic        ray_any_hit;
  logic [4:0]  num_spheres;
  logic        sph_rd_en;
  logic [3:0]  sph_rd_addr;
  logic        hit_issue;
  logic [3:0]  hit_issue_idx;
  logic        hit_ret_valid;
  logic        hit_ret_hit;
  logic [31:0] hit_ret_t;
  logic [3:0]  hit_ret_idx;
  logic        res_valid;
  logic        res_ready;
  logic        res_hit;
  logic [31:0] res_t;
  logic [3:0]  res_idx;
  logic        err;

  typedef struct {
    logic        hit;
    logic [31:0] t;
    SphereIndex  idx;
    int          lat;
    int          start;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rd_count = 0;
  int          last_hs = -100;
  int          n_results = 0;
  logic        hit_tab[16];
  logic [31:0] t_tab[16];
  int          ret_at[int];
  bit          stray_req = 0;
  logic        res_valid_prev = 1'b0;

  sphere_hit_scheduler #(
    .MAX_SPHERES(16),
    .IDX_W      (4),
    .T_W        (32),
    .HIT_LAT    (HL)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ray_valid    (ray_valid),
    .ray_ready    (ray_ready),
    .ray_any_hit  (ray_any_hit),
    .num_spheres  (num_spheres),
    .sph_rd_en    (sph_rd_en),
    .sph_rd_addr  (sph_rd_addr),
    .hit_issue    (hit_issue),
    .hit_issue_idx(hit_issue_idx),
    .hit_ret_valid(hit_ret_valid),
    .hit_ret_hit  (hit_ret_hit),
    .hit_ret_t    (hit_ret_t),
    .hit_ret_idx  (hit_ret_idx),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_hit      (res_hit),
    .res_t        (res_t),
    .res_idx      (res_idx),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hit unit model: capture issues on the falling edge, answer HL cycles later.
  initial forever begin
    @(negedge clk);
    if (resetn && hit_issue) ret_at[cyc + HL] = int'(hit_issue_idx);
  end

  initial begin
    hit_ret_valid = 1'b0;
    hit_ret_hit   = 1'b0;
    hit_ret_t     = '0;
    hit_ret_idx   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) ret_at.delete();
      if (stray_req) begin
        hit_ret_valid = 1'b1;
        hit_ret_hit   = 1'b1;
        hit_ret_t     = 32'h10;
        hit_ret_idx   = 4'd0;
        stray_req     = 0;
      end else if (ret_at.exists(cyc)) begin
        int i;
        i = ret_at[cyc];
        ret_at.delete(cyc);
        hit_ret_valid = 1'b1;
        hit_ret_hit   = hit_tab[i];
        hit_ret_t     = t_tab[i];
        hit_ret_idx   = i[3:0];
      end else begin
        hit_ret_valid = 1'b0;
        hit_ret_hit   = 1'b0;
        hit_ret_t     = '0;
        hit_ret_idx   = '0;
      end
    end
  end

  // Monitor: read address sequence, result latency, result values held until handshake.
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      res_valid_prev = 1'b0;
    end else begin
      if (sph_rd_en) begin
        chk("rd_addr", 64'(sph_rd_addr), 64'(rd_count));
        rd_count++;
      end
      if (res_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got res_valid=1 expected no result pending (cycle %0d)", cyc);
        end else begin
          if (!res_valid_prev) chk("latency", 64'(cyc - sb[0].start), 64'(sb[0].lat));
          chk("res_hit", 64'(res_hit), 64'(sb[0].hit));
          chk("res_t", 64'(res_t), 64'(sb[0].t));
          chk("res_idx", 64'(res_idx), 64'(sb[0].idx));
          chk("ray_ready_busy", 64'(ray_ready), 64'd0);
          if (res_ready) begin
            n_results++;
            $display("result %0d: hit=%0d t=0x%0h idx=%0d cycle=%0d", n_results, res_hit, res_t, res_idx, cyc - sb[0].start);
            last_hs = cyc;
            void'(sb.pop_front());
          end
        end
      end
      res_valid_prev = res_valid;
    end
  end

  task automatic clear_tab();
    for (int i = 0; i < 16; i++) begin
      hit_tab[i] = 1'b0;
      t_tab[i]   = 32'h0;
    end
  endtask

  task automatic set_hit(input int i, input logic [31:0] t);
    hit_tab[i] = 1'b1;
    t_tab[i]   = t;
  endtask

  // Called at posedge+1; presents the ray for exactly one cycle.
  task automatic send_ray(input logic any, input int n, input logic eh, input logic [31:0] et,
                          input int ei, input int lat);
    exp_t e;
    chk("ray_ready_idle", 64'(ray_ready), 64'd1);
    e.hit   = eh;
    e.t     = et;
    e.idx   = ei[3:0];
    e.lat   = lat;
    e.start = cyc;
    sb.push_back(e);
    rd_count    = 0;
    ray_valid   = 1'b1;
    ray_any_hit = any;
    num_spheres = n[4:0];
    @(posedge clk);
    #1;
    ray_valid   = 1'b0;
    ray_any_hit = 1'b0;
    num_spheres = '0;
  endtask

  task automatic wait_done(input int exp_rd);
    int i;
    for (i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("result_timeout", 64'(sb.size()), 64'd0);
    chk("rd_count", 64'(rd_count), 64'(exp_rd));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ray_ready", 64'(ray_ready), 64'd1);
    chk("rst_sph_rd_en", 64'(sph_rd_en), 64'd0);
    chk("rst_hit_issue", 64'(hit_issue), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_hit", 64'(res_hit), 64'd0);
    chk("rst_res_t", 64'(res_t), 64'(T_FAR));
    chk("rst_res_idx", 64'(res_idx), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
  endtask

  initial begin
    resetn      = 1'b0;
    ray_valid   = 1'b0;
    ray_any_hit = 1'b0;
    num_spheres = '0;
    res_ready   = 1'b1;
    clear_tab();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Closest hit among three.
    clear_tab();
    set_hit(0, 32'h500);
    set_hit(1, 32'h200);
    set_hit(2, 32'h300);
    send_ray(1'b0, 3, 1'b1, 32'h200, 1, 9);
    wait_done(3);

    // Any-hit, freeze occurs after all four are issued; later smaller t ignored.
    clear_tab();
    set_hit(1, 32'h800);
    set_hit(3, 32'h100);
    send_ray(1'b1, 4, 1'b1, 32'h800, 1, 10);
    wait_done(4);

    // Any-hit with a longer list: issuing stops the cycle the first hit returns.
    clear_tab();
    set_hit(1, 32'h800);
    set_hit(4, 32'h50);
    send_ray(1'b1, 10, 1'b1, 32'h800, 1, 12);
    wait_done(6);

    // Empty list.
    clear_tab();
    send_ray(1'b0, 0, 1'b0, T_FAR, 0, 1);
    wait_done(0);

    // Equal distances keep the lower index; result held while res_ready is low.
    clear_tab();
    set_hit(0, 32'h400);
    set_hit(1, 32'h400);
    res_ready = 1'b0;
    send_ray(1'b0, 2, 1'b1, 32'h400, 0, 8);
    for (int i = 0; i < 50 && !res_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("res_valid_seen", 64'(res_valid), 64'd1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    res_ready = 1'b1;
    wait_done(2);

    // Reset in the middle of issuing with two spheres outstanding.
    clear_tab();
    send_ray(1'b0, 8, 1'b0, T_FAR, 0, 14);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sb.delete();
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("err_before_stray", 64'(err), 64'd0);
    stray_req = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("err_after_stray", 64'(err), 64'd1);
    chk("stray_ray_ready", 64'(ray_ready), 64'd1);
    chk("stray_res_valid", 64'(res_valid), 64'd0);

    // Full list with no hits, then a clamped request accepted right after the handshake.
    clear_tab();
    send_ray(1'b0, 16, 1'b0, T_FAR, 0, 22);
    wait_done(16);
    chk("b2b_gap", 64'(cyc - last_hs), 64'd1);
    set_hit(14, 32'h9);
    set_hit(15, 32'h7);
    send_ray(1'b0, 31, 1'b1, 32'h7, 15, 22);
    wait_done(16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL global_timeout: got no completion expected finish before 100000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
